// File: rtl/seq_tx_pkg.sv
// rtl/seq_tx_pkg.sv - shared types and sizing helpers for the serial transmitter
// Optional parity frame bit: SEQ_TX_PARITY_EN
package seq_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int GAP_W = 4;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Bits on the line per frame, including the trailing parity bit when enabled
  function automatic int frame_width(input int width);
`ifdef SEQ_TX_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/seq_tx_shifter.sv
// rtl/seq_tx_shifter.sv - load/shift register presenting the frame MSB-first
// Appends the even-parity bit below the data LSB when SEQ_TX_PARITY_EN is defined.
module seq_tx_shifter
  import seq_tx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] word_in,
  input  logic             load,
  input  logic             shift_en,
  output logic             msb
);

  localparam int FRAME_W = frame_width(WIDTH);

  logic [FRAME_W-1:0] sreg;
  logic [FRAME_W-1:0] load_val;

`ifdef SEQ_TX_PARITY_EN
  assign load_val = {word_in, ^word_in};
`else
  assign load_val = word_in;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= load_val;
    end else if (shift_en) begin
      sreg <= {sreg[FRAME_W-2:0], 1'b0};
    end
  end

  assign msb = sreg[FRAME_W-1];

endmodule

// File: rtl/seq_tx_serializer.sv
// rtl/seq_tx_serializer.sv - parallel-in, MSB-first serial transmitter with inter-frame gap
// Optional parity frame bit: SEQ_TX_PARITY_EN
module seq_tx_serializer
  import seq_tx_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic             D_out,
  output logic             D_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam int                 FRAME_W  = frame_width(WIDTH);
  localparam int                 CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]   BIT_LOAD = CNT_W'(FRAME_W - 1);
  localparam logic [GAP_W-1:0]   GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
  logic             load;
  logic             shift_en;
  logic             msb;

  seq_tx_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clock    (clock),
    .reset    (reset),
    .word_in  (word_in),
    .load     (load),
    .shift_en (shift_en),
    .msb      (msb)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      gap_cnt <= gap_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    gap_cnt_nxt = gap_cnt;
    load        = 1'b0;
    shift_en    = 1'b0;
    case (state)
      IDLE: begin
        if (word_valid) begin
          load        = 1'b1;
          bit_cnt_nxt = BIT_LOAD;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (bit_cnt == '0) begin
          if (GAP_CYCLES == 0) begin
            state_nxt = IDLE;
          end else begin
            state_nxt   = GAP;
            gap_cnt_nxt = GAP_LOAD;
          end
        end else begin
          bit_cnt_nxt = bit_cnt - 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode registered state only, so reset clears them without waiting for a clock
  assign word_ready = (state == IDLE);
  assign D_valid    = (state == SHIFT);
  assign D_out      = D_valid & msb;
  assign busy       = (state != IDLE);
  assign frame_done = D_valid && (bit_cnt == '0);

endmodule

// File: tb/tb_seq_tx_serializer.sv
// tb/tb_seq_tx_serializer.sv - scoreboard bench for seq_tx_serializer (GAP_CYCLES=1 and 0 instances)
module tb_seq_tx_serializer;

`ifdef SEQ_TX_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] word_in1, word_in0;
  logic       word_valid1, word_valid0;
  logic       word_ready1, D_out1, D_valid1, busy1, frame_done1;
  logic       word_ready0, D_out0, D_valid0, busy0, frame_done0;

  always #5 clock = ~clock;

  seq_tx_serializer #(.WIDTH(8), .GAP_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset), .word_in(word_in1), .word_valid(word_valid1),
    .word_ready(word_ready1), .D_out(D_out1), .D_valid(D_valid1), .busy(busy1),
    .frame_done(frame_done1)
  );

  seq_tx_serializer #(.WIDTH(8), .GAP_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset), .word_in(word_in0), .word_valid(word_valid0),
    .word_ready(word_ready0), .D_out(D_out0), .D_valid(D_valid0), .busy(busy0),
    .frame_done(frame_done0)
  );

  typedef struct packed {
    logic b;
    logic done;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   b2b1 = 1'b0;
  bit   seen_frame1 = 1'b0;
  bit   prev_valid1 = 1'b0;
  int   idle_run1 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input bit sel, input logic [7:0] w);
    exp_t e;
    for (int i = 7; i >= 0; i--) begin
      e.b    = w[i];
      e.done = (i == 0) && (FL == 8);
      if (sel) q1.push_back(e); else q0.push_back(e);
    end
`ifdef SEQ_TX_PARITY_EN
    e.b    = ^w;
    e.done = 1'b1;
    if (sel) q1.push_back(e); else q0.push_back(e);
`endif
  endtask

  // Called at a falling edge; returns at the falling edge of the first bit cycle
  task automatic send(input bit sel, input logic [7:0] w);
    int t = 0;
    if (sel) begin word_in1 = w; word_valid1 = 1'b1; end
    else     begin word_in0 = w; word_valid0 = 1'b1; end
    while (!(sel ? word_ready1 : word_ready0) && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (t >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: word %0h never accepted", w);
    end else begin
      push_frame(sel, w);
    end
    @(posedge clock);
    @(negedge clock);
    if (sel) begin word_valid1 = 1'b0; word_in1 = ~w; end
    else     begin word_valid0 = 1'b0; word_in0 = ~w; end
  endtask

  task automatic drain();
    int t = 0;
    while ((q1.size() != 0 || q0.size() != 0) && t < 60) begin
      @(negedge clock);
      t++;
    end
    check("drain_q1", q1.size(), 0);
    check("drain_q0", q0.size(), 0);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      if (D_valid1) begin
        if (!prev_valid1 && b2b1 && seen_frame1) check("b2b_idle_gap", idle_run1, 2);
        if (q1.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_bit1: got D_out=%0b with no expected bit", D_out1);
        end else begin
          e = q1.pop_front();
          check("d_out1", D_out1, e.b);
          check("frame_done1", frame_done1, e.done);
        end
        idle_run1   = 0;
        seen_frame1 = 1'b1;
      end else begin
        check("idle_dout1", D_out1, 0);
        check("idle_fdone1", frame_done1, 0);
        idle_run1++;
      end
      prev_valid1 = D_valid1;
      if (D_valid0) begin
        if (q0.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_bit0: got D_out=%0b with no expected bit", D_out0);
        end else begin
          e = q0.pop_front();
          check("d_out0", D_out0, e.b);
          check("frame_done0", frame_done0, e.done);
        end
      end else begin
        check("idle_dout0", D_out0, 0);
        check("idle_fdone0", frame_done0, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    word_in1 = 8'h00; word_valid1 = 1'b0;
    word_in0 = 8'h00; word_valid0 = 1'b0;
    #12;
    reset = 1'b1;
    @(negedge clock);

    // Idle after reset
    for (int c = 0; c < 5; c++) begin
      check("rst_ready1", word_ready1, 1);
      check("rst_valid1", D_valid1, 0);
      check("rst_dout1", D_out1, 0);
      check("rst_busy1", busy1, 0);
      check("rst_ready0", word_ready0, 1);
      check("rst_busy0", busy0, 0);
      @(negedge clock);
    end

    // A5 with frame/gap timing
    send(1'b1, 8'hA5);
    for (int c = 1; c <= FL; c++) begin
      check("shift_busy", busy1, 1);
      check("shift_ready", word_ready1, 0);
      check("shift_valid", D_valid1, 1);
      @(negedge clock);
    end
    check("gap_valid", D_valid1, 0);
    check("gap_busy", busy1, 1);
    check("gap_ready", word_ready1, 0);
    @(negedge clock);
    check("post_gap_ready", word_ready1, 1);
    check("post_gap_busy", busy1, 0);
    drain();

    // Back-to-back FF then 00 with valid held
    b2b1 = 1'b1;
    send(1'b1, 8'hFF);
    send(1'b1, 8'h00);
    drain();
    b2b1 = 1'b0;

    // Zero-gap instance
    send(1'b0, 8'h3C);
    for (int c = 1; c <= FL; c++) @(negedge clock);
    check("g0_idle_valid", D_valid0, 0);
    check("g0_ready", word_ready0, 1);
    check("g0_busy", busy0, 0);
    drain();

    // Reset mid-frame after three bits of C3
    send(1'b1, 8'hC3);
    @(negedge clock);
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", D_valid1, 0);
    check("arst_busy", busy1, 0);
    check("arst_ready", word_ready1, 1);
    check("arst_dout", D_out1, 0);
    q1.delete();
    seen_frame1 = 1'b0;
    prev_valid1 = 1'b0;
    @(negedge clock);
    #2;
    reset = 1'b1;
    @(negedge clock);
    check("rel_ready", word_ready1, 1);
    check("rel_valid", D_valid1, 0);
    send(1'b1, 8'h81);
    drain();

`ifdef SEQ_TX_PARITY_EN
    send(1'b1, 8'h07);
    for (int c = 1; c <= FL; c++) begin
      if (c == FL) begin
        check("parity_bit", D_out1, 1);
        check("parity_done", frame_done1, 1);
        check("parity_valid", D_valid1, 1);
      end
      @(negedge clock);
    end
    drain();
`endif

    repeat (4) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_tx_serializer.md
Name: seq_tx_serializer

Overview:
- Transmit-side counterpart to the serial sequence recogniser. Accepts a parallel word through a valid/ready handshake and shifts it out MSB-first, one bit per clock, on a serial line (D_out, D_valid).
- Feeds recogniser-type blocks with known bit streams, both in the design and as a stimulus source.
- Registered outputs only; single clock domain.

Parameters:
- WIDTH, 8, data bits per frame (legal values 2..32).
- GAP_CYCLES, 1, extra idle cycles inserted after each frame (0..15).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- word_in  input  WIDTH  parallel word to send.
- word_valid  input  1  word_in holds a valid word.
- word_ready  output  1  block can accept a word this cycle.
- D_out  output  1  serial data bit.
- D_valid  output  1  D_out carries a frame bit this cycle.
- busy  output  1  a frame or gap is in progress.
- frame_done  output  1  one-cycle pulse during the last bit of a frame.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, shift register=0, bit counter=0, gap counter=0.
  - D_out=0, D_valid=0, busy=0, frame_done=0, word_ready=1.
  - Asserting reset mid-frame abandons the frame immediately. No partial frame resumes after release.
- States: IDLE, SHIFT, GAP (GAP is skipped when GAP_CYCLES=0).
- IDLE:
  - word_ready=1 (decoded from state), D_valid=0, D_out=0.
  - Accept at edge k when word_valid=1 and word_ready=1: load the shift register, set bit counter=WIDTH-1, go to SHIFT.
  - word_in is sampled only at the accept edge; later changes are ignored.
- SHIFT:
  - D_valid=1, D_out=current MSB of the shift register, busy=1, word_ready=0.
  - Each edge shifts left by 1 (zero fill) and decrements the bit counter.
  - Bit i (MSB=WIDTH-1) appears in the cycle after edge k+(WIDTH-1-i). Latency from accept edge to first bit = 1 cycle.
  - frame_done=1 in the cycle where the bit counter=0 (the last bit).
  - At the next edge: go to GAP with gap counter=GAP_CYCLES-1, or to IDLE if GAP_CYCLES=0.
- GAP:
  - D_valid=0, D_out=0, busy=1, word_ready=0.
  - Decrement the gap counter each edge; go to IDLE when it reaches 0.
- Inter-frame spacing: minimum GAP_CYCLES+1 cycles with D_valid=0 between frames. No back-to-back frames.
- word_valid while word_ready=0 is ignored, not queued. The producer must hold it until accepted.
- Arithmetic: bit counter is $clog2(WIDTH+1) bits wide; gap counter is 4 bits. Neither counter wraps.

Optional Feature:
- Macro: SEQ_TX_PARITY_EN
- Defined:
  - An even-parity bit (XOR of the accepted word) is sent with D_valid=1 in the cycle after the last data bit. Frame length becomes WIDTH+1.
  - frame_done moves to the parity-bit cycle.
  - Parity is computed at the accept edge and stored.
- Undefined: frame is exactly WIDTH bits; no parity logic is generated.

Decomposition:
- Package seq_tx_pkg holds:
  - state enum (IDLE, SHIFT, GAP);
  - localparam GAP_W=4;
  - function for bit-counter width.
- One sub-module, seq_tx_shifter:
  - WIDTH-bit load/shift register with MSB output, load and shift-enable inputs.
  - Contains the parity generator when SEQ_TX_PARITY_EN is defined.
- The FSM and counters stay in the top module.

Test Plan:
- Reset then idle, word_valid=0 for 5 cycles -> word_ready=1, D_valid=0, D_out=0, busy=0 throughout.
- WIDTH=8, GAP_CYCLES=1, send 8'hA5 at edge k -> D_out=1,0,1,0,0,1,0,1 in cycles k+1..k+8 with D_valid=1. frame_done only in cycle k+8. GAP in cycle k+9. word_ready=1 from cycle k+10.
- Send 8'hFF then 8'h00 with word_valid held high -> second word accepted at the first IDLE cycle. Exactly 2 cycles with D_valid=0 between frames. Both frames are bit-exact.
- GAP_CYCLES=0, send 8'h3C -> 0,0,1,1,1,1,0,0 is emitted, then 1 idle cycle, then word_ready=1.
- Drive reset=0 mid-frame, after 3 bits of 8'hC3 -> D_valid and busy drop asynchronously. After release, word_ready=1 and the next word 8'h81 is sent cleanly.
- With SEQ_TX_PARITY_EN, send 8'h07 -> 8 data bits, then parity bit 1 in cycle k+9 with frame_done=1.
